// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ACK,
    STROBE,
    RELEASE
  } arb_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ADDR_TO,
    ERR_REL_TO,
    ERR_DROP
  } arb_err_t;

  localparam logic [15:0] StatMax = 16'hFFFF;

  // Saturating 16-bit increment used by the statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == StatMax) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request searching upward
// from ptr_i + 1 with wrap-around.
module rr_priority_pick #(
  parameter int unsigned DEVICE_MAX_NUMBER = 4
) (
  input  logic [DEVICE_MAX_NUMBER-1:0]         req_i,
  input  logic [$clog2(DEVICE_MAX_NUMBER)-1:0] ptr_i,
  output logic [DEVICE_MAX_NUMBER-1:0]         gnt_o,
  output logic [$clog2(DEVICE_MAX_NUMBER)-1:0] idx_o,
  output logic                                 any_o
);

  localparam int unsigned IdxW = $clog2(DEVICE_MAX_NUMBER);

  // Walk the ring once, starting just after the last winner.
  always_comb begin
    int unsigned        cand;
    logic [IdxW-1:0]    cidx;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int unsigned i = 1; i <= DEVICE_MAX_NUMBER; i++) begin
      cand = (32'(ptr_i) + i) % DEVICE_MAX_NUMBER;
      cidx = IdxW'(cand);
      if (!any_o && req_i[cidx]) begin
        any_o       = 1'b1;
        idx_o       = cidx;
        gnt_o[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with handshake sequencer and timeout watchdog.
// Optional statistics counters are enabled by defining ARB_STATS_EN.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned DEVICE_MAX_NUMBER = 4,
  parameter int unsigned CLK_MAX_TIMEOUT   = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DEVICE_MAX_NUMBER-1:0]         barq_i,
  output logic [DEVICE_MAX_NUMBER-1:0]         bagd_o,
  input  logic                                 address_valid_i,
  output logic                                 target_ready_o,
  output logic                                 data_strobe_o,
  output logic [1:0]                           error_o,
`ifdef ARB_STATS_EN
  output logic [15:0]                          stat_grants_o,
  output logic [15:0]                          stat_faults_o,
`endif
  output logic [$clog2(DEVICE_MAX_NUMBER)-1:0] grant_id_o
);

  localparam int unsigned IdxW = $clog2(DEVICE_MAX_NUMBER);
  localparam int unsigned TW   = $clog2(CLK_MAX_TIMEOUT + 1);
  localparam logic [TW-1:0] TimerLast = TW'(CLK_MAX_TIMEOUT - 1);

  arb_state_t                   state_q, state_d;
  arb_err_t                     err_q, err_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic [IdxW-1:0]              ptr_q, ptr_d;
  logic [IdxW-1:0]              id_q, id_d;
  logic [DEVICE_MAX_NUMBER-1:0] bagd_q, bagd_d;
  logic                         tr_q, tr_d;
  logic                         ds_q, ds_d;
  logic                         grant_issue;
  logic                         fault_set;

  logic [DEVICE_MAX_NUMBER-1:0] pick_gnt;
  logic [IdxW-1:0]              pick_idx;
  logic                         pick_any;

  rr_priority_pick #(
    .DEVICE_MAX_NUMBER(DEVICE_MAX_NUMBER)
  ) u_pick (
    .req_i(barq_i),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  // Next-state, error, pointer and timer logic.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    grant_issue = 1'b0;
    fault_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = GRANT;
          id_d        = pick_idx;
          ptr_d       = pick_idx;
          err_d       = ERR_NONE;
          grant_issue = 1'b1;
        end
      end
      GRANT: begin
        if (address_valid_i) begin
          state_d = ACK;
        end else if (!barq_i[id_q]) begin
          state_d   = IDLE;
          err_d     = ERR_DROP;
          fault_set = 1'b1;
        end else if (timer_q == TimerLast) begin
          state_d   = IDLE;
          err_d     = ERR_ADDR_TO;
          fault_set = 1'b1;
        end
      end
      ACK:    state_d = STROBE;
      STROBE: state_d = RELEASE;
      RELEASE: begin
        if (!barq_i[id_q]) begin
          state_d = IDLE;
        end else if (timer_q == TimerLast) begin
          state_d   = IDLE;
          err_d     = ERR_REL_TO;
          fault_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timer restarts on any state change and only runs while waiting on the master.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == GRANT || state_q == RELEASE) && (timer_q != '1)) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Moore outputs decoded from the next state so they register cleanly.
  always_comb begin
    if (state_d == IDLE) begin
      bagd_d = '0;
    end else if (state_q == IDLE) begin
      bagd_d = pick_gnt;
    end else begin
      bagd_d = bagd_q;
    end
    tr_d = (state_d == ACK);
    ds_d = (state_d == STROBE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
      timer_q <= '0;
      ptr_q   <= IdxW'(DEVICE_MAX_NUMBER - 1);
      id_q    <= '0;
      bagd_q  <= '0;
      tr_q    <= 1'b0;
      ds_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      bagd_q  <= bagd_d;
      tr_q    <= tr_d;
      ds_q    <= ds_d;
    end
  end

  assign bagd_o         = bagd_q;
  assign target_ready_o = tr_q;
  assign data_strobe_o  = ds_q;
  assign error_o        = err_q;
  assign grant_id_o     = id_q;

`ifdef ARB_STATS_EN
  logic [15:0] grants_q, grants_d;
  logic [15:0] faults_q, faults_d;

  // Saturating grant and fault counters.
  always_comb begin
    grants_d = grant_issue ? sat_inc16(grants_q) : grants_q;
    faults_d = fault_set ? sat_inc16(faults_q) : faults_q;
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants_q <= '0;
      faults_q <= '0;
    end else begin
      grants_q <= grants_d;
      faults_q <= faults_d;
    end
  end

  assign stat_grants_o = grants_q;
  assign stat_faults_o = faults_q;
`else
  logic unused_stats;
  assign unused_stats = grant_issue ^ fault_set;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed self-checking bench for bus_rr_arbiter (4 devices, timeout 10).
module tb_bus_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] barq_i;
  logic [3:0] bagd_o;
  logic       address_valid_i;
  logic       target_ready_o;
  logic       data_strobe_o;
  logic [1:0] error_o;
  logic [1:0] grant_id_o;
`ifdef ARB_STATS_EN
  logic [15:0] stat_grants_o;
  logic [15:0] stat_faults_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bus_rr_arbiter #(
    .DEVICE_MAX_NUMBER(4),
    .CLK_MAX_TIMEOUT(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .barq_i(barq_i),
    .bagd_o(bagd_o),
    .address_valid_i(address_valid_i),
    .target_ready_o(target_ready_o),
    .data_strobe_o(data_strobe_o),
    .error_o(error_o),
`ifdef ARB_STATS_EN
    .stat_grants_o(stat_grants_o),
    .stat_faults_o(stat_faults_o),
`endif
    .grant_id_o(grant_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [1:0] exp_err);
    chk({tag, ".bagd"}, 16'(bagd_o), 16'h0);
    chk({tag, ".tr"}, 16'(target_ready_o), 16'h0);
    chk({tag, ".ds"}, 16'(data_strobe_o), 16'h0);
    chk({tag, ".err"}, 16'(error_o), 16'(exp_err));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0] exp_g;
    int         exp_id;

    // Reset values.
    reset = 1'b1;
    barq_i = 4'b0000;
    address_valid_i = 1'b0;
    #2;
    chk_idle_outputs("reset", 2'b00);
    chk("reset.gid", 16'(grant_id_o), 16'h0);
    tick();
    tick();
    reset = 1'b0;

    // Single transaction, device 0.
    barq_i = 4'b0001;
    tick();
    chk("t1.bagd", 16'(bagd_o), 16'h1);
    chk("t1.gid", 16'(grant_id_o), 16'h0);
    chk("t1.err", 16'(error_o), 16'h0);
    tick();
    chk("t1.hold", 16'(bagd_o), 16'h1);
    chk("t1.tr0", 16'(target_ready_o), 16'h0);
    address_valid_i = 1'b1;
    tick();
    chk("t1.tr", 16'(target_ready_o), 16'h1);
    chk("t1.ds0", 16'(data_strobe_o), 16'h0);
    address_valid_i = 1'b0;
    tick();
    chk("t1.ds", 16'(data_strobe_o), 16'h1);
    chk("t1.tr_off", 16'(target_ready_o), 16'h0);
    tick();
    chk("t1.rel_ds", 16'(data_strobe_o), 16'h0);
    chk("t1.rel_bagd", 16'(bagd_o), 16'h1);
    barq_i = 4'b0000;
    tick();
    chk_idle_outputs("t1.idle", 2'b00);

    // Fresh pointer, all four requesting: order 0,1,2,3,0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    barq_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_id = k % 4;
      exp_g = 4'b0001 << exp_id;
      tick();
      chk("t2.bagd", 16'(bagd_o), 16'(exp_g));
      chk("t2.gid", 16'(grant_id_o), 16'(exp_id));
      address_valid_i = 1'b1;
      tick();
      chk("t2.tr", 16'(target_ready_o), 16'h1);
      address_valid_i = 1'b0;
      tick();
      chk("t2.ds", 16'(data_strobe_o), 16'h1);
      tick();
      barq_i = 4'b1111 & ~exp_g;
      tick();
      chk("t2.gap", 16'(bagd_o), 16'h0);
      barq_i = 4'b1111;
    end
    barq_i = 4'b0000;
    tick();

    // Address timeout on device 2.
    barq_i = 4'b0100;
    tick();
    chk("t3.bagd", 16'(bagd_o), 16'h4);
    chk("t3.gid", 16'(grant_id_o), 16'h2);
    for (int i = 0; i < 9; i++) tick();
    chk("t3.still", 16'(bagd_o), 16'h4);
    tick();
    chk("t3.drop", 16'(bagd_o), 16'h0);
    chk("t3.err", 16'(error_o), 16'h1);
    barq_i = 4'b0000;
    tick();
    tick();
    chk("t3.errhold", 16'(error_o), 16'h1);

    // Release timeout on device 1; device 2 pending next.
    barq_i = 4'b0010;
    tick();
    chk("t4.bagd", 16'(bagd_o), 16'h2);
    chk("t4.errclr", 16'(error_o), 16'h0);
    barq_i = 4'b0110;
    address_valid_i = 1'b1;
    tick();
    address_valid_i = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 9; i++) tick();
    chk("t4.still", 16'(bagd_o), 16'h2);
    tick();
    chk("t4.drop", 16'(bagd_o), 16'h0);
    chk("t4.err", 16'(error_o), 16'h2);
    barq_i = 4'b0100;
    tick();
    chk("t4.next", 16'(bagd_o), 16'h4);
    chk("t4.gid", 16'(grant_id_o), 16'h2);
    chk("t4.errclr2", 16'(error_o), 16'h0);
    address_valid_i = 1'b1;
    tick();
    address_valid_i = 1'b0;
    tick();
    tick();
    barq_i = 4'b0000;
    tick();
    chk("t4.idle", 16'(bagd_o), 16'h0);

    // Device 3 drops its request while granted.
    barq_i = 4'b1000;
    tick();
    chk("t5.bagd", 16'(bagd_o), 16'h8);
    tick();
    barq_i = 4'b0000;
    tick();
    chk_idle_outputs("t5.drop", 2'b11);
    address_valid_i = 1'b1;
    tick();
    chk("t5.av_ign_tr", 16'(target_ready_o), 16'h0);
    chk("t5.av_ign_bagd", 16'(bagd_o), 16'h0);
    address_valid_i = 1'b0;
`ifdef ARB_STATS_EN
    chk("t5.grants", stat_grants_o, 16'd9);
    chk("t5.faults", stat_faults_o, 16'd3);
`endif

    // Reset during ACK.
    barq_i = 4'b0010;
    tick();
    chk("t6.bagd", 16'(bagd_o), 16'h2);
    address_valid_i = 1'b1;
    tick();
    chk("t6.tr", 16'(target_ready_o), 16'h1);
    reset = 1'b1;
    #1;
    chk_idle_outputs("t6.rst", 2'b00);
    chk("t6.gid", 16'(grant_id_o), 16'h0);
`ifdef ARB_STATS_EN
    chk("t6.grants", stat_grants_o, 16'd0);
    chk("t6.faults", stat_faults_o, 16'd0);
`endif
    address_valid_i = 1'b0;
    tick();
    chk("t6.rst_hold", 16'(data_strobe_o), 16'h0);
    reset = 1'b0;
    barq_i = 4'b0011;
    tick();
    chk("t6.first", 16'(bagd_o), 16'h1);
    chk("t6.first_gid", 16'(grant_id_o), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
